// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite types plus the UART register map and FSM state encodings.
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef logic [AXI_DATA_W/8-1:0] strb_t;

    // Byte offsets within the 32-byte window; decode only looks at addr[4:2]
    localparam logic [4:0] UART_TXDATA = 5'h00;
    localparam logic [4:0] UART_RXDATA = 5'h04;
    localparam logic [4:0] UART_STATUS = 5'h08;
    localparam logic [4:0] UART_CTRL   = 5'h0C;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_OVERRUN  = 3;
    localparam int ST_TX_COUNT = 4;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_WAIT_W,
        WR_WAIT_AW,
        WR_EXEC,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_RESP
    } rd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite bus bundle with master and slave views.
interface axi_lite_if;
    import axi_lite_pkg::*;

    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [AXI_DATA_W-1:0] wdata;
    strb_t                 wstrb;
    logic                  wvalid;
    logic                  wready;
    resp_t                 bresp;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    resp_t                 rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO; pointers carry a wrap bit so count = wr - rd.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == CNT_W'(DEPTH));
    assign empty_o = (count_o == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[IDX_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/axi_lite_uart_regs.sv
// AXI-lite register front end for the UART core: TX FIFO, RX holding register, STATUS, CTRL.
//   write FSM state | meaning
//   WR_IDLE         | AW and W both ready, nothing captured
//   WR_WAIT_W       | address captured, waiting for write data
//   WR_WAIT_AW      | data captured, waiting for address
//   WR_EXEC         | apply the write, compute bresp
//   WR_RESP         | bvalid held until bready
//   read FSM state  | meaning
//   RD_IDLE         | arready high, read sampled on accept
//   RD_RESP         | rvalid held with stable rdata/rresp until rready
module axi_lite_uart_regs
    import axi_lite_pkg::*;
#(
    parameter int          TX_DEPTH    = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    axi_lite_if.slave   s_axi,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] baud_div,
    output logic        irq
);

    localparam int CNT_W = $clog2(TX_DEPTH) + 1;

    wr_state_t   wr_state_q, wr_state_d;
    rd_state_t   rd_state_q, rd_state_d;
    logic        awready_q, wready_q, arready_q;
    logic [2:0]  awidx_q;
    logic [16:0] wdata_q;
    logic [2:0]  wstrb_q;
    resp_t       bresp_q, bresp_d;
    logic [31:0] rdata_q, rdata_d;
    resp_t       rresp_q, rresp_d;
    logic [16:0] ctrl_q, ctrl_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_full_q, rx_full_d;
    logic        overrun_q, overrun_d;
    logic        irq_q;

    logic             aw_hs, w_hs, ar_hs;
    logic [4:0]       aw_off, ar_off;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             rx_pop, status_rd;
    logic [31:0]      status_word;
    logic             unused_bits;

    assign aw_hs  = s_axi.awvalid && awready_q;
    assign w_hs   = s_axi.wvalid && wready_q;
    assign ar_hs  = s_axi.arvalid && arready_q;
    assign aw_off = {awidx_q, 2'b00};
    assign ar_off = {s_axi.araddr[4:2], 2'b00};

    assign unused_bits = ^{s_axi.awaddr[AXI_ADDR_W-1:5], s_axi.awaddr[1:0],
                           s_axi.araddr[AXI_ADDR_W-1:5], s_axi.araddr[1:0],
                           s_axi.wdata[AXI_DATA_W-1:17], s_axi.wstrb[3]};

    uart_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .push_i  (fifo_push),
        .wdata_i (wdata_q[7:0]),
        .pop_i   (fifo_pop),
        .rdata_o (tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign fifo_pop = tx_ready && !fifo_empty;
    assign tx_valid = !fifo_empty;
    assign baud_div = ctrl_q[15:0];
    assign irq      = irq_q;

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = (wr_state_q == WR_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = (rd_state_q == RD_RESP);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = WR_EXEC;
                else if (aw_hs)    wr_state_d = WR_WAIT_W;
                else if (w_hs)     wr_state_d = WR_WAIT_AW;
            end
            WR_WAIT_W:  if (w_hs)  wr_state_d = WR_EXEC;
            WR_WAIT_AW: if (aw_hs) wr_state_d = WR_EXEC;
            WR_EXEC:    wr_state_d = WR_RESP;
            WR_RESP:    if (s_axi.bready) wr_state_d = WR_IDLE;
            default:    wr_state_d = WR_IDLE;
        endcase
    end

    // Full check uses the registered count, so a same-cycle TX pop never makes room
    always_comb begin
        ctrl_d    = ctrl_q;
        bresp_d   = bresp_q;
        fifo_push = 1'b0;
        if (wr_state_q == WR_EXEC) begin
            bresp_d = RESP_OKAY;
            case (aw_off)
                UART_TXDATA: begin
                    if (wstrb_q[0]) begin
                        if (fifo_full) bresp_d   = RESP_SLVERR;
                        else           fifo_push = 1'b1;
                    end
                end
                UART_CTRL: begin
                    if (wstrb_q[0]) ctrl_d[7:0]  = wdata_q[7:0];
                    if (wstrb_q[1]) ctrl_d[15:8] = wdata_q[15:8];
                    if (wstrb_q[2]) ctrl_d[16]   = wdata_q[16];
                end
                default: bresp_d = RESP_SLVERR;
            endcase
        end
    end

    always_comb begin
        status_word                     = '0;
        status_word[ST_TX_FULL]         = fifo_full;
        status_word[ST_TX_EMPTY]        = fifo_empty;
        status_word[ST_RX_FULL]         = rx_full_q;
        status_word[ST_OVERRUN]         = overrun_q;
        status_word[ST_TX_COUNT +: 4]   = 4'(fifo_count);
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rx_pop     = 1'b0;
        status_rd  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_RESP;
                    rdata_d    = '0;
                    rresp_d    = RESP_OKAY;
                    case (ar_off)
                        UART_RXDATA: begin
                            if (rx_full_q) begin
                                rdata_d = {24'b0, rx_byte_q};
                                rx_pop  = 1'b1;
                            end
                        end
                        UART_STATUS: begin
                            rdata_d   = status_word;
                            status_rd = 1'b1;
                        end
                        UART_CTRL: rdata_d = {15'b0, ctrl_q};
                        default:   rresp_d = RESP_SLVERR;
                    endcase
                end
            end
            RD_RESP: if (s_axi.rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // A fresh overrun in the same cycle as a STATUS read wins over the clear
    always_comb begin
        rx_byte_d = rx_byte_q;
        rx_full_d = rx_full_q;
        overrun_d = overrun_q;
        if (status_rd) overrun_d = 1'b0;
        if (rx_valid) begin
            if (!rx_full_q || rx_pop) begin
                rx_byte_d = rx_data;
                rx_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_pop) begin
            rx_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            ctrl_q     <= {1'b0, DEFAULT_DIV};
            rx_byte_q  <= '0;
            rx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            awready_q  <= (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_AW);
            wready_q   <= (wr_state_d == WR_IDLE) || (wr_state_d == WR_WAIT_W);
            arready_q  <= (rd_state_d == RD_IDLE);
            if (aw_hs) awidx_q <= s_axi.awaddr[4:2];
            if (w_hs) begin
                wdata_q <= s_axi.wdata[16:0];
                wstrb_q <= s_axi.wstrb[2:0];
            end
            bresp_q    <= bresp_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            ctrl_q     <= ctrl_d;
            rx_byte_q  <= rx_byte_d;
            rx_full_q  <= rx_full_d;
            overrun_q  <= overrun_d;
            irq_q      <= ctrl_q[16] && rx_full_q;
        end
    end

endmodule

// File: tb/tb_axi_lite_uart_regs.sv
// Directed bench for axi_lite_uart_regs with hand-computed expected values.
module tb_axi_lite_uart_regs;
    import axi_lite_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] baud_div;
    logic        irq;

    axi_lite_if bus();

    axi_lite_uart_regs #(
        .TX_DEPTH    (4),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_axi    (bus),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .baud_div (baud_div),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_b(output logic [1:0] resp, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.bvalid && lat < 40);
        check_val("b_valid_seen", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output int lat);
        bit aw_ok = 1'b0;
        bit w_ok  = 1'b0;
        bit aw_hs, w_hs;
        int t = 0;
        @(posedge clk); #1;
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.wvalid  = 1'b1;
        while (!(aw_ok && w_ok) && t < 40) begin
            @(negedge clk);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            if (aw_hs) begin bus.awvalid = 1'b0; aw_ok = 1'b1; end
            if (w_hs)  begin bus.wvalid  = 1'b0; w_ok  = 1'b1; end
            t++;
        end
        check_val("wr_accept", {30'd0, aw_ok, w_ok}, 32'd3);
        wait_b(resp, lat);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        bit ok = 1'b0;
        bit hs;
        int t = 0;
        @(posedge clk); #1;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!ok && t < 40) begin
            @(negedge clk);
            hs = bus.arvalid && bus.arready;
            @(posedge clk); #1;
            if (hs) begin bus.arvalid = 1'b0; ok = 1'b1; end
            t++;
        end
        check_val("rd_accept", 32'(ok), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rvalid && lat < 40);
        check_val("r_valid_seen", 32'(bus.rvalid), 32'd1);
        data = bus.rdata;
        resp = bus.rresp;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        axi_read(addr, d, r, lat);
        check_val({tag, "_rdata"}, d, exp_data);
        check_val({tag, "_rresp"}, 32'(r), 32'(exp_resp));
        check_val({tag, "_rlat"}, lat, 32'd1);
    endtask

    task automatic wr_check(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] r;
        int         lat;
        axi_write(addr, data, strb, r, lat);
        check_val({tag, "_bresp"}, 32'(r), 32'(exp_resp));
        check_val({tag, "_blat"}, lat, 32'd2);
    endtask

    logic [1:0] resp_v;
    int         lat_v;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        tx_ready    = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_awready", 32'(bus.awready), 32'd0);
        check_val("rst_wready",  32'(bus.wready),  32'd0);
        check_val("rst_arready", 32'(bus.arready), 32'd0);
        check_val("rst_bvalid",  32'(bus.bvalid),  32'd0);
        check_val("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check_val("rst_bresp",   32'(bus.bresp),   32'd0);
        check_val("rst_rdata",   bus.rdata,        32'd0);
        check_val("rst_tx_valid", 32'(tx_valid),   32'd0);
        check_val("rst_irq",     32'(irq),         32'd0);
        check_val("rst_baud",    32'(baud_div),    32'd434);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_awready", 32'(bus.awready), 32'd1);
        check_val("post_rst_arready", 32'(bus.arready), 32'd1);

        rd_check("ctrl_rst",   32'h0C, 32'h0000_01B2, RESP_OKAY);
        rd_check("status_rst", 32'h08, 32'h0000_0002, RESP_OKAY);

        // W leads AW by three cycles
        @(posedge clk); #1;
        bus.wdata  = 32'h41;
        bus.wstrb  = 4'h1;
        bus.wvalid = 1'b1;
        @(negedge clk);
        check_val("wfirst_wready", 32'(bus.wready), 32'd1);
        @(posedge clk); #1;
        bus.wvalid = 1'b0;
        @(negedge clk);
        check_val("wfirst_wready_drop", 32'(bus.wready),  32'd0);
        check_val("wfirst_awready",     32'(bus.awready), 32'd1);
        @(posedge clk);
        @(posedge clk); #1;
        bus.awaddr  = 32'h00;
        bus.awvalid = 1'b1;
        @(negedge clk);
        check_val("wfirst_aw_hs", 32'(bus.awready), 32'd1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        wait_b(resp_v, lat_v);
        check_val("wfirst_blat",  lat_v, 32'd2);
        check_val("wfirst_bresp", 32'(resp_v), 32'(RESP_OKAY));
        @(negedge clk);
        check_val("wfirst_tx_valid", 32'(tx_valid), 32'd1);
        check_val("wfirst_tx_data",  32'(tx_data),  32'h41);
        rd_check("status_cnt1", 32'h08, 32'h0000_0010, RESP_OKAY);

        @(posedge clk); #1; tx_ready = 1'b1;
        @(posedge clk); #1; tx_ready = 1'b0;
        @(negedge clk);
        check_val("drain1_tx_valid", 32'(tx_valid), 32'd0);

        for (int i = 0; i < 5; i++)
            wr_check($sformatf("tx_push%0d", i), 32'h00, 32'h10 + i, 4'h1,
                     (i < 4) ? RESP_OKAY : RESP_SLVERR);
        rd_check("status_full", 32'h08, 32'h0000_0041, RESP_OKAY);

        @(posedge clk); #1; tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("drain_valid%0d", i), 32'(tx_valid), 32'd1);
            check_val($sformatf("drain_data%0d", i),  32'(tx_data),  32'h10 + i);
        end
        @(negedge clk);
        check_val("drain_done", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        wr_check("ctrl_strb", 32'h0C, 32'h0001_1234, 4'b0101, RESP_OKAY);
        rd_check("ctrl_strb", 32'h0C, 32'h0001_0134, RESP_OKAY);
        check_val("ctrl_baud", 32'(baud_div), 32'h0134);

        rd_check("rx_empty", 32'h04, 32'h0, RESP_OKAY);
        @(posedge clk); #1; rx_data = 8'h5A; rx_valid = 1'b1;
        @(posedge clk); #1; rx_valid = 1'b0;
        @(negedge clk);
        check_val("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check_val("irq_set", 32'(irq), 32'd1);
        @(posedge clk); #1; rx_data = 8'h33; rx_valid = 1'b1;
        @(posedge clk); #1; rx_valid = 1'b0;
        rd_check("rx_pop",       32'h04, 32'h0000_005A, RESP_OKAY);
        rd_check("status_ovr",   32'h08, 32'h0000_000A, RESP_OKAY);
        rd_check("status_ovr_clr", 32'h08, 32'h0000_0002, RESP_OKAY);
        check_val("irq_clear", 32'(irq), 32'd0);

        rd_check("rd_unmapped", 32'h14, 32'h0, RESP_SLVERR);
        wr_check("wr_status",   32'h08, 32'hFF, 4'hF, RESP_SLVERR);
        wr_check("wr_unmapped", 32'h18, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR);
        rd_check("status_same", 32'h08, 32'h0000_0002, RESP_OKAY);
        wr_check("tx_nostrb",   32'h00, 32'h99, 4'b0010, RESP_OKAY);
        check_val("tx_nostrb_valid", 32'(tx_valid), 32'd0);
        rd_check("ctrl_alias", 32'h10C, 32'h0001_0134, RESP_OKAY);

        bus.bready = 1'b0;
        axi_write(32'h0C, 32'h0000_01B2, 4'b0011, resp_v, lat_v);
        check_val("stall_bresp0", 32'(resp_v), 32'(RESP_OKAY));
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check_val("stall_bvalid",  32'(bus.bvalid),  32'd1);
                    check_val("stall_bresp",   32'(bus.bresp),   32'(RESP_OKAY));
                    check_val("stall_awready", 32'(bus.awready), 32'd0);
                end
            end
            rd_check("stall_ctrl", 32'h0C, 32'h0001_01B2, RESP_OKAY);
        join
        @(posedge clk); #1; bus.bready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("stall_release_bvalid",  32'(bus.bvalid),  32'd0);
        check_val("stall_release_awready", 32'(bus.awready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
